gradient_stream_ctrl: RTL and testbench

Flow controller that wraps the fixed-latency, non-stallable Sobel gradient-magnitude pipeline (square, sum, CORDIC sqrt) in AXI4-Stream handshakes. It admits pixels only when downstream space is guaranteed, and carries SOF and EOL sideband around the pipeline. It realigns results with that sideband and provides enable and flush sequencing plus status.

---
 rtl/gradient_pkg.sv | 20 ++
 rtl/sync_fwft_fifo.sv | 53 +++++
 rtl/gradient_stream_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gradient_stream_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types for the gradient stream controller.
// No logic; parameters and typedefs only.
// Not applicable (no handshakes).
package gradient_pkg;

    localparam int DATA_WIDTH_DEF = 12;

    // Sideband carried around the fixed-latency pipeline.
    typedef struct packed {
        logic sof;
        logic eol;
    } sband_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// Head is visible the cycle after a push into an empty FIFO; pop is same-cycle.
// No internal backpressure: pushes when full and pops when empty are ignored.
module sync_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;

    // Extra pointer bit distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr - rd_ptr) == FULL_CNT);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/gradient_stream_ctrl.sv
// AXI4-Stream wrapper around a fixed-latency, non-stallable gradient magnitude pipeline.
// Issue to the pipeline 1 cycle after accept; output follows pipeline latency plus 1 FIFO cycle.
// Pixels are admitted only while output credits remain, so the result FIFO never overflows.
module gradient_stream_ctrl
    import gradient_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [2*DATA_WIDTH-1:0] s_tdata,
    input  logic                    s_tuser,
    input  logic                    s_tlast,
    output logic                    grad_in_valid,
    output logic [DATA_WIDTH-1:0]   grad_gx,
    output logic [DATA_WIDTH-1:0]   grad_gy,
    input  logic                    grad_out_valid,
    input  logic [DATA_WIDTH-1:0]   grad_out_data,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tuser,
    output logic                    m_tlast,
    output logic                    busy,
    output logic [15:0]             frame_cnt,
    output logic                    err
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    state_t                  state;
    logic [CNT_WIDTH-1:0]    reserved;
    logic [CNT_WIDTH-1:0]    in_flight;
    logic                    accept;
    logic                    out_hs;
    logic                    ret_live;
    logic                    res_push;
    logic                    res_empty;
    logic                    sb_empty;
    logic [DATA_WIDTH-1:0]   res_head;
    sband_t                  sb_head;
    sband_t                  sb_push_dat;

    // Credits count every admitted beat until it leaves the output port.
    assign s_tready = (state == RUN) && (reserved < DEPTH_CNT);
    assign accept   = s_tvalid && s_tready;
    assign m_tvalid = !res_empty && (state != FLUSH);
    assign out_hs   = m_tvalid && m_tready;

    // A return only counts when something was actually issued.
    assign ret_live = grad_out_valid && (in_flight != '0);
    assign res_push = ret_live && (state != FLUSH);

    assign m_tdata  = m_tvalid ? res_head : '0;
    assign m_tuser  = m_tvalid && sb_head.sof;
    assign m_tlast  = m_tvalid && sb_head.eol;
    assign busy     = (in_flight != '0) || !res_empty || !sb_empty;

    assign sb_push_dat.sof = s_tuser;
    assign sb_push_dat.eol = s_tlast;

    // Control FSM; flush overrides everything and FLUSH waits for the pipeline to empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= FLUSH;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= IDLE;
                FLUSH:   if (in_flight == '0) state <= enable ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output credit tracking; flush returns all credits since both FIFOs are emptied.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            reserved <= '0;
        end else begin
            case ({accept, out_hs})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase
        end
    end

    // Beats inside the pipeline; survives flush so late results can be recognised and dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({accept, ret_live})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Registered issue into the pipeline, one cycle after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grad_in_valid <= 1'b0;
            grad_gx       <= '0;
            grad_gy       <= '0;
        end else begin
            grad_in_valid <= accept;
            if (accept) begin
                grad_gx <= s_tdata[DATA_WIDTH-1:0];
                grad_gy <= s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    // Sticky error: unexpected pipeline result while running, or lost sideband alignment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((grad_out_valid && (in_flight == '0) && (state == RUN)) ||
                     (!res_empty && sb_empty)) begin
            err <= 1'b1;
        end
    end

    // Count frames as their SOF beat leaves the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (out_hs && sb_head.sof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    sync_fwft_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push     (res_push),
        .push_dat (grad_out_data),
        .pop      (out_hs),
        .head_dat (res_head),
        .empty    (res_empty)
    );

    sync_fwft_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_sb_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push     (accept),
        .push_dat (sb_push_dat),
        .pop      (out_hs),
        .head_dat (sb_head),
        .empty    (sb_empty)
    );

endmodule

// File: tb/tb_gradient_stream_ctrl.sv
// Testbench for gradient_stream_ctrl with a behavioural fixed-latency pipeline stub.
// Expected outputs come from an integer square-root reference and a scoreboard queue.
// Output port backpressure is driven constant or randomised per test phase.
module tb_gradient_stream_ctrl;
    import gradient_pkg::*;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int LAT   = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            flush = 1'b0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [2*DW-1:0] s_tdata = '0;
    logic            s_tuser = 1'b0;
    logic            s_tlast = 1'b0;
    logic            grad_in_valid;
    logic [DW-1:0]   grad_gx;
    logic [DW-1:0]   grad_gy;
    logic            grad_out_valid;
    logic [DW-1:0]   grad_out_data;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic            m_tuser;
    logic            m_tlast;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic            err;

    gradient_stream_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .grad_in_valid(grad_in_valid), .grad_gx(grad_gx), .grad_gy(grad_gy),
        .grad_out_valid(grad_out_valid), .grad_out_data(grad_out_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .busy(busy), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- pipeline stub: fixed latency, floating-point sqrt ----------------
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];
    logic           inj_vld = 1'b0;
    logic [DW-1:0]  inj_dat = '0;
    int             outstanding;

    function automatic logic [DW-1:0] stub_mag(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int xi = int'(x);
        int yi = int'(y);
        return DW'($rtoi($sqrt(real'(xi * xi + yi * yi))));
    endfunction

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], grad_in_valid};
        pd[0] <= stub_mag(grad_gx, grad_gy);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign grad_out_valid = pv[LAT-1] | inj_vld;
    assign grad_out_data  = inj_vld ? inj_dat : pd[LAT-1];

    always_comb outstanding = $countones(pv) + int'(grad_in_valid);

    // ---------------- reference model and scoreboard ----------------
    function automatic int ref_mag(input int x, input int y);
        int v = x * x + y * y;
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] mag;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] exp_frames = '0;

    // Random ready on the output when enabled
    bit rdy_rand = 1'b0;
    always begin
        @(negedge clk);
        if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: order, sideband alignment and hold-while-stalled
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_dat;
    logic          hold_usr;
    logic          hold_lst;
    bit            flush_watch = 1'b0;
    bit            flush_leak = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n || flush) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, hold_dat);
                chk("hold_side", {m_tuser, m_tlast}, {hold_usr, hold_lst});
            end
            if (flush_watch && m_tvalid) flush_leak = 1'b1;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d expected no beat", m_tdata);
                end else begin
                    cur = exp_q.pop_front();
                    chk("out_data", m_tdata, cur.mag);
                    chk("out_tuser", m_tuser, cur.sof);
                    chk("out_tlast", m_tlast, cur.eol);
                    if (cur.sof) exp_frames = exp_frames + 16'd1;
                end
            end
            hold_pend = m_tvalid && !m_tready;
            hold_dat  = m_tdata;
            hold_usr  = m_tuser;
            hold_lst  = m_tlast;
        end
    end

    // ---------------- drivers (called and returning on a negedge) ----------------
    task automatic send_beat(input int gx, input int gy, input bit sof, input bit eol,
                             input int mag, input bit chk_issue);
        int   waited = 0;
        exp_t e;
        s_tvalid = 1'b1;
        s_tdata  = {DW'(gy), DW'(gx)};
        s_tuser  = sof;
        s_tlast  = eol;
        while (!s_tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) begin
            chk("accept_timeout", 0, 1);
            s_tvalid = 1'b0;
            return;
        end
        e.mag = DW'(mag);
        e.sof = sof;
        e.eol = eol;
        exp_q.push_back(e);
        @(negedge clk);
        s_tvalid = 1'b0;
        if (chk_issue) begin
            chk("issue_valid", grad_in_valid, 1);
            chk("issue_gx", grad_gx, gx);
            chk("issue_gy", grad_gy, gy);
        end
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while ((busy || exp_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_drained"}, (busy == 1'b0) && (exp_q.size() == 0), 1);
    endtask

    typedef struct {
        int gx;
        int gy;
        bit sof;
        bit eol;
        int mag;
    } vec_t;

    vec_t tbl[8];
    int   acc;
    int   w;
    int   gx;
    int   gy;

    initial begin
        tbl[0] = '{3, 4, 1'b1, 1'b0, 5};
        tbl[1] = '{3, 4, 1'b0, 1'b0, 5};
        tbl[2] = '{3, 4, 1'b0, 1'b0, 5};
        tbl[3] = '{3, 4, 1'b0, 1'b1, 5};
        tbl[4] = '{6, 8, 1'b1, 1'b0, 10};
        tbl[5] = '{5, 12, 1'b0, 1'b0, 13};
        tbl[6] = '{0, 0, 1'b0, 1'b0, 0};
        tbl[7] = '{2047, 2047, 1'b0, 1'b1, 2894};

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_grad_in_valid", grad_in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_m_tdata", m_tdata, 0);

        // First line of four 3-4-5 pixels, then a second table line
        @(negedge clk);
        rst_n    = 1'b1;
        enable   = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++)
            send_beat(tbl[i].gx, tbl[i].gy, tbl[i].sof, tbl[i].eol, tbl[i].mag, 1'b1);
        @(negedge clk);
        chk("issue_idle_low", grad_in_valid, 0);
        wait_drain("line1");
        chk("line1_frame_cnt", frame_cnt, 1);
        chk("line1_err", err, 0);
        for (int i = 4; i < 8; i++)
            send_beat(tbl[i].gx, tbl[i].gy, tbl[i].sof, tbl[i].eol, tbl[i].mag, 1'b1);
        wait_drain("line2");
        chk("line2_frame_cnt", frame_cnt, exp_frames);

        // Backpressure: exactly DEPTH accepts with the output stalled
        m_tready = 1'b0;
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            gx = $urandom_range(0, 2047);
            gy = $urandom_range(0, 2047);
            s_tdata = {DW'(gy), DW'(gx)};
            s_tuser = (acc == 0);
            s_tlast = (acc == DEPTH - 1);
            if (s_tready) begin
                cur.mag = DW'(ref_mag(gx, gy));
                cur.sof = s_tuser;
                cur.eol = s_tlast;
                exp_q.push_back(cur);
                acc++;
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        chk("bp_accepts", acc, DEPTH);
        chk("bp_tready_low", s_tready, 0);
        chk("bp_busy", busy, 1);
        m_tready = 1'b1;
        @(negedge clk);
        chk("bp_tready_after_pop", s_tready, 1);
        wait_drain("bp");
        chk("bp_frame_cnt", frame_cnt, exp_frames);

        // Randomised traffic with random output readiness
        rdy_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            gx = $urandom_range(0, 2047);
            gy = $urandom_range(0, 2047);
            send_beat(gx, gy, (n % 100) == 0, (n % 10) == 9, ref_mag(gx, gy), 1'b0);
        end
        rdy_rand = 1'b0;
        m_tready = 1'b1;
        wait_drain("rand");
        chk("rand_frame_cnt", frame_cnt, exp_frames);
        chk("rand_err", err, 0);

        // Flush with beats both buffered and in flight
        m_tready = 1'b0;
        for (int i = 0; i < 12; i++)
            send_beat(i + 1, 2 * i, i == 0, i == 11, ref_mag(i + 1, 2 * i), 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_flush_m_tvalid", m_tvalid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_tready = 1'b1;
        exp_q.delete();
        flush_leak = 1'b0;
        flush_watch = 1'b1;
        chk("flush_m_tvalid", m_tvalid, 0);
        chk("flush_s_tready", s_tready, 0);
        chk("flush_busy", busy, 1);
        w = 0;
        while (!s_tready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("flush_back_to_run", s_tready, 1);
        chk("flush_pipe_empty", outstanding, 0);
        repeat (3) @(negedge clk);
        flush_watch = 1'b0;
        chk("flush_no_output", flush_leak, 0);
        chk("flush_busy_clear", busy, 0);
        chk("flush_err", err, 0);
        for (int i = 0; i < 4; i++)
            send_beat(tbl[i].gx, tbl[i].gy, tbl[i].sof, tbl[i].eol, tbl[i].mag, 1'b0);
        wait_drain("post_flush");
        chk("post_flush_frame_cnt", frame_cnt, exp_frames);

        // enable low mid-line: admission stops, admitted beats drain
        send_beat(tbl[4].gx, tbl[4].gy, tbl[4].sof, tbl[4].eol, tbl[4].mag, 1'b0);
        send_beat(tbl[5].gx, tbl[5].gy, tbl[5].sof, tbl[5].eol, tbl[5].mag, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_tready", s_tready, 0);
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (s_tready) acc++;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        chk("disable_no_accept", acc, 0);
        wait_drain("disable");
        chk("disable_busy", busy, 0);

        // Spurious pipeline result while running
        enable = 1'b1;
        repeat (2) @(negedge clk);
        inj_dat = 12'd123;
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        chk("inject_err", err, 1);
        chk("inject_dropped", m_tvalid, 0);
        chk("inject_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("inject_err_sticky", err, 1);

        // Reset mid-operation clears everything; late results dropped in IDLE
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++)
            send_beat(i + 2, i, i == 0, 1'b0, ref_mag(i + 2, i), 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_frames = '0;
        chk("midrst_err", err, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_s_tready", s_tready, 0);
        rst_n = 1'b1;
        m_tready = 1'b1;
        repeat (12) @(negedge clk);
        chk("late_result_err", err, 0);
        chk("late_result_m_tvalid", m_tvalid, 0);
        chk("late_result_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
